// File: rtl/scan_index_gen_if.sv
// rtl/scan_index_gen_if.sv - scan index sequencer control/output bundle
//   en    : scan enable, low pauses the scan
//   mask  : per-position enable, bit i = position i
//   val   : current position index (to the 3-to-8 decoder)
//   valid : index is live; decoder output is blanked when low
//   wrap  : one-cycle pulse on a scan frame start
// master = controller/observer side, slave = the sequencer.
interface scan_index_gen_if;
  logic       en;
  logic [7:0] mask;
  logic [2:0] val;
  logic       valid;
  logic       wrap;

  modport master (output en, mask, input val, valid, wrap);
  modport slave  (input en, mask, output val, valid, wrap);
endinterface

// File: rtl/scan_index_gen.sv
// rtl/scan_index_gen.sv - registered 3-bit scan index sequencer for an 8-slot bank
// Steps through the enabled positions of the bank with a fixed dwell per position,
// skipping disabled positions and pulsing wrap at each frame start.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : scan_index_gen_if.slave (en, mask in; val, valid, wrap out, all registered)
// Optional feature macro: SCAN_BLANK_EN inserts BLANK_CYC blanked cycles (valid=0)
// between positions; without it the index advances with valid held high.
module scan_index_gen #(
  parameter int CLK_DIV = 50000,
  parameter int NUM_POS = 8
`ifdef SCAN_BLANK_EN
  , parameter int BLANK_CYC = 4
`endif
) (
  input logic             clk,
  input logic             rst,
  scan_index_gen_if.slave bus
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [7:0] POS_MASK = 8'((1 << NUM_POS) - 1);

  typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div, div_nxt;
  logic [2:0]      val_q, val_nxt;
  logic            valid_q, valid_nxt;
  logic            wrap_q, wrap_nxt;
  logic [7:0]      m;
  logic [2:0]      nxt_pos;
  logic [2:0]      first_pos;
  logic            div_last;

`ifdef SCAN_BLANK_EN
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  logic [BW-1:0]   bcnt, bcnt_nxt;
  logic            wrap_pend, wrap_pend_nxt;
  logic            blank_last;
  assign blank_last = (bcnt == BW'(BLANK_CYC - 1));
`endif

  // First enabled position strictly after p, wrapping modulo NUM_POS. Descending
  // search so the nearest candidate is the last one written.
  function automatic logic [2:0] next_set(input logic [2:0] p, input logic [7:0] mm);
    logic [2:0] r;
    int         idx;
    r = p;
    for (int k = NUM_POS; k >= 1; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_POS) idx = idx - NUM_POS;
      if (mm[idx[2:0]]) r = idx[2:0];
    end
    return r;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] mm);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      if (mm[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign m         = bus.mask & POS_MASK;
  assign nxt_pos   = next_set(val_q, m);
  assign first_pos = lowest_set(m);
  assign div_last  = (div == DW'(CLK_DIV - 1));

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef SCAN_BLANK_EN
      bcnt      <= '0;
      wrap_pend <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      val_q   <= val_nxt;
      valid_q <= valid_nxt;
      wrap_q  <= wrap_nxt;
`ifdef SCAN_BLANK_EN
      bcnt      <= bcnt_nxt;
      wrap_pend <= wrap_pend_nxt;
`endif
    end
  end

  // Next-state logic; an empty mask always falls back to IDLE, en=0 freezes
  always_comb begin
    state_nxt = state;
    if (m == 8'h00) begin
      state_nxt = IDLE;
    end else if (bus.en) begin
      case (state)
        IDLE:  state_nxt = DWELL;
`ifdef SCAN_BLANK_EN
        DWELL: if (div_last) state_nxt = BLANK;
        BLANK: if (blank_last) state_nxt = DWELL;
`else
        DWELL: state_nxt = DWELL;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next output/counter values. valid and wrap default low so a pause or an empty
  // mask blanks the index on the next edge while val and the counters hold.
  always_comb begin
    div_nxt   = div;
    val_nxt   = val_q;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;
`ifdef SCAN_BLANK_EN
    bcnt_nxt      = bcnt;
    wrap_pend_nxt = wrap_pend;
`endif
    if (m != 8'h00 && bus.en) begin
      case (state)
        IDLE: begin
          val_nxt   = first_pos;
          valid_nxt = 1'b1;
          wrap_nxt  = 1'b1;
          div_nxt   = '0;
        end
        DWELL: begin
          valid_nxt = 1'b1;
          if (div_last) begin
            div_nxt = '0;
            val_nxt = nxt_pos;
`ifdef SCAN_BLANK_EN
            // Frame-start pulse is deferred until the new index is shown
            valid_nxt     = 1'b0;
            wrap_pend_nxt = (nxt_pos <= val_q);
            bcnt_nxt      = '0;
`else
            wrap_nxt = (nxt_pos <= val_q);
`endif
          end else begin
            div_nxt = div + DW'(1);
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (blank_last) begin
            valid_nxt = 1'b1;
            wrap_nxt  = wrap_pend;
            div_nxt   = '0;
          end else begin
            bcnt_nxt = bcnt + BW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.val   = val_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule
